// File: rtl/div_unit_p_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_p_pkg
// Description : Shared divider state type and handshake constants.
// Revision    : 1.0 - initial parametrised divider release
// ============================================================================
package div_unit_p_pkg;

   typedef enum logic [1:0] {
      DivIdle = 2'd0,
      DivOn   = 2'd1,
      DivEnd  = 2'd2
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // Legacy HI/LO pair type, only meaningful for 32-bit instances.
   typedef logic [63:0] DoubleReg_t;

endpackage
`default_nettype wire

// File: rtl/div_step_p.sv
`default_nettype none
// ============================================================================
// Module      : div_step_p
// Description : One combinational radix-2 restoring division step.
// Revision    : 1.0 - initial parametrised divider release
// ============================================================================
module div_step_p
   import div_unit_p_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic             o_qbit
);

   logic [WIDTH+1:0] w_diff;

   // Extra top bit acts as the borrow: set means the subtraction must be undone.
   assign w_diff = {1'b0, i_rem} - {2'b00, i_divisor};
   assign o_qbit = ~w_diff[WIDTH+1];
   assign o_rem  = o_qbit ? w_diff[WIDTH:0] : i_rem;

endmodule
`default_nettype wire

// File: rtl/div_unit_p.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_p
// Description : Parametrised radix-2 restoring divider for DIV/DIVU in EX.
// Revision    : 1.0 - initial parametrised divider release
// ============================================================================
module div_unit_p
   import div_unit_p_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int EARLY_OUT = 1,
   parameter int CNT_W     = $clog2(WIDTH+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 div_by_zero_o
);

   div_state_e           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH:0]     r_work;
   logic [WIDTH-1:0]     r_divisor;
   logic                 r_signed;
   logic                 r_sign1;
   logic                 r_sign2;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_dbz;

   logic [WIDTH-1:0]     w_abs1;
   logic [WIDTH-1:0]     w_abs2;
   logic                 w_early;
   logic [2*WIDTH:0]     w_shift;
   logic [WIDTH:0]       w_step_rem;
   logic                 w_step_q;
   logic [2*WIDTH:0]     w_next_work;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_rem;
   logic [WIDTH-1:0]     w_quot_fix;
   logic [WIDTH-1:0]     w_rem_fix;
   logic                 w_accept;

   assign w_abs1   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign w_abs2   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
   assign w_accept = (start_i == DivStart) && !annul_i;

   generate
      if (EARLY_OUT != 0) begin : g_early_on
         assign w_early = (w_abs1 < w_abs2);
      end else begin : g_early_off
         assign w_early = 1'b0;
      end
   endgenerate

   // Partial remainder lives in the upper WIDTH+1 bits, quotient shifts in at bit 0.
   assign w_shift = r_work << 1;

   div_step_p #(
      .WIDTH     (WIDTH)
   ) u_step (
      .i_rem     (w_shift[2*WIDTH:WIDTH]),
      .i_divisor (r_divisor),
      .o_rem     (w_step_rem),
      .o_qbit    (w_step_q)
   );

   assign w_next_work = {w_step_rem, w_shift[WIDTH-1:1], w_step_q};
   assign w_quot      = w_next_work[WIDTH-1:0];
   assign w_rem       = w_next_work[2*WIDTH-1:WIDTH];
   assign w_quot_fix  = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quot : w_quot;
   assign w_rem_fix   = (r_signed && r_sign1) ? -w_rem : w_rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= DivIdle;
         r_cnt     <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_signed  <= 1'b0;
         r_sign1   <= 1'b0;
         r_sign2   <= 1'b0;
         r_result  <= '0;
         r_dbz     <= 1'b0;
      end else begin
         case (r_state)
            DivIdle: begin
               if (w_accept) begin
                  r_signed  <= signed_div_i;
                  r_sign1   <= opdata1_i[WIDTH-1];
                  r_sign2   <= opdata2_i[WIDTH-1];
                  r_divisor <= w_abs2;
                  if (opdata2_i == '0) begin
                     r_result <= '0;
                     r_dbz    <= 1'b1;
                     r_state  <= DivEnd;
                  end else if (w_early) begin
                     r_result <= {opdata1_i, {WIDTH{1'b0}}};
                     r_dbz    <= 1'b0;
                     r_state  <= DivEnd;
                  end else begin
                     r_work  <= {{(WIDTH+1){1'b0}}, w_abs1};
                     r_cnt   <= '0;
                     r_state <= DivOn;
                  end
               end
            end
            DivOn: begin
               if (annul_i) begin
                  r_result <= '0;
                  r_dbz    <= 1'b0;
                  r_state  <= DivIdle;
               end else begin
                  r_work <= w_next_work;
                  r_cnt  <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(WIDTH-1)) begin
                     r_result <= {w_rem_fix, w_quot_fix};
                     r_dbz    <= 1'b0;
                     r_state  <= DivEnd;
                  end
               end
            end
            DivEnd: begin
               if (annul_i || (start_i == DivStop)) begin
                  r_result <= '0;
                  r_dbz    <= 1'b0;
                  r_state  <= DivIdle;
               end
            end
            default: begin
               r_result <= '0;
               r_dbz    <= 1'b0;
               r_state  <= DivIdle;
            end
         endcase
      end
   end

   assign ready_o       = (r_state == DivEnd) ? DivResultReady : DivResultNotReady;
   assign busy_o        = (r_state == DivOn);
   assign result_o      = ready_o ? r_result : '0;
   assign div_by_zero_o = ready_o & r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit_p
// Description : Directed self-checking bench for div_unit_p (32-bit and 8-bit).
// Revision    : 1.0 - initial parametrised divider release
// ============================================================================
module tb_div_unit_p;

   logic         clk = 1'b0;
   logic         rst;
   logic         sgn;
   logic [31:0]  op1;
   logic [31:0]  op2;
   logic         st_eo;
   logic         st_ne;
   logic         st_8;
   logic         annul;

   logic [63:0]  res_eo, res_ne;
   logic [15:0]  res_8;
   logic         rdy_eo, rdy_ne, rdy_8;
   logic         bsy_eo, bsy_ne, bsy_8;
   logic         dbz_eo, dbz_ne, dbz_8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_unit_p #(.WIDTH(32), .EARLY_OUT(1)) u_dut_eo (
      .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
      .start_i(st_eo), .annul_i(annul), .result_o(res_eo), .ready_o(rdy_eo),
      .busy_o(bsy_eo), .div_by_zero_o(dbz_eo)
   );

   div_unit_p #(.WIDTH(32), .EARLY_OUT(0)) u_dut_ne (
      .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
      .start_i(st_ne), .annul_i(annul), .result_o(res_ne), .ready_o(rdy_ne),
      .busy_o(bsy_ne), .div_by_zero_o(dbz_ne)
   );

   div_unit_p #(.WIDTH(8), .EARLY_OUT(1)) u_dut_8 (
      .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1[7:0]), .opdata2_i(op2[7:0]),
      .start_i(st_8), .annul_i(annul), .result_o(res_8), .ready_o(rdy_8),
      .busy_o(bsy_8), .div_by_zero_o(dbz_8)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic read_dut(input int sel, output logic rdy, output logic bsy,
                           output logic dbz, output logic [127:0] res);
      case (sel)
         0:       begin rdy = rdy_eo; bsy = bsy_eo; dbz = dbz_eo; res = {64'd0, res_eo}; end
         1:       begin rdy = rdy_ne; bsy = bsy_ne; dbz = dbz_ne; res = {64'd0, res_ne}; end
         default: begin rdy = rdy_8;  bsy = bsy_8;  dbz = dbz_8;  res = {112'd0, res_8}; end
      endcase
   endtask

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       st_eo = v;
         1:       st_ne = v;
         default: st_8  = v;
      endcase
   endtask

   // Start an operation, measure edges to ready, optionally stall in END, then release.
   task automatic run_op(input string tag, input int sel, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input int exp_n,
                         input logic [127:0] exp_res, input logic exp_dbz, input int hold);
      int n;
      logic rdy, bsy, dbz;
      logic [127:0] res;
      sgn = s; op1 = a; op2 = b;
      set_start(sel, 1'b1);
      n = 0; rdy = 1'b0;
      while (!rdy && n < 100) begin
         @(posedge clk); #1;
         n++;
         read_dut(sel, rdy, bsy, dbz, res);
      end
      check({tag, "_lat"}, 128'(n), 128'(exp_n));
      check({tag, "_res"}, res, exp_res);
      check({tag, "_dbz"}, {127'd0, dbz}, {127'd0, exp_dbz});
      for (int i = 0; i < hold; i++) begin
         op1 = op1 + 32'd3;
         @(posedge clk); #1;
         read_dut(sel, rdy, bsy, dbz, res);
         check({tag, "_hold_res"}, res, exp_res);
         check({tag, "_hold_rdy"}, {127'd0, rdy}, 128'd1);
      end
      set_start(sel, 1'b0);
      @(posedge clk); #1;
      read_dut(sel, rdy, bsy, dbz, res);
      check({tag, "_idle"}, {res, 1'b0, rdy, dbz}, {128'd0, 3'b000});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic rdy, bsy, dbz, seen;
      logic [127:0] res;
      rst = 1'b1; sgn = 1'b0; op1 = '0; op2 = '0;
      st_eo = 1'b0; st_ne = 1'b0; st_8 = 1'b0; annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_eo", {res_eo, rdy_eo, bsy_eo, dbz_eo}, '0);
      check("rst_ne", {res_ne, rdy_ne, bsy_ne, dbz_ne}, '0);
      check("rst_8",  {res_8, rdy_8, bsy_8, dbz_8}, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("u100_7",   0, 1'b0, 32'd100,      32'd7,        33, {64'd0, 32'd2, 32'd14}, 1'b0, 0);
      run_op("sm100_7",  0, 1'b1, 32'hFFFFFF9C, 32'd7,        33, {64'd0, 32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 0);
      run_op("s_minm1",  0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {64'd0, 32'd0, 32'h80000000}, 1'b0, 0);
      run_op("s7_m2",    1, 1'b1, 32'd7,        32'hFFFFFFFE, 33, {64'd0, 32'd1, 32'hFFFFFFFD}, 1'b0, 0);
      run_op("dbz",      0, 1'b0, 32'h1234,     32'd0,         1, 128'd0, 1'b1, 0);
      run_op("eo5_9",    0, 1'b0, 32'd5,        32'd9,         1, {64'd0, 32'd5, 32'd0}, 1'b0, 0);
      run_op("ne5_9",    1, 1'b0, 32'd5,        32'd9,        33, {64'd0, 32'd5, 32'd0}, 1'b0, 0);
      run_op("eo_sm5_9", 0, 1'b1, 32'hFFFFFFFB, 32'd9,         1, {64'd0, 32'hFFFFFFFB, 32'd0}, 1'b0, 0);

      // Annul partway through ON
      sgn = 1'b0; op1 = 32'd50; op2 = 32'd3; st_eo = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      read_dut(0, rdy, bsy, dbz, res);
      check("annul_busy", {127'd0, bsy}, 128'd1);
      annul = 1'b1;
      @(posedge clk); #1;
      read_dut(0, rdy, bsy, dbz, res);
      check("annul_idle", {res, bsy, rdy, dbz}, '0);
      annul = 1'b0; st_eo = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (rdy_eo) seen = 1'b1;
      end
      check("annul_noready", {127'd0, seen}, 128'd0);

      run_op("u1000_10", 0, 1'b0, 32'd1000, 32'd10, 33, {64'd0, 32'd0, 32'd100}, 1'b0, 5);

      run_op("w8_255_16", 2, 1'b0, 32'd255, 32'd16, 9, {112'd0, 8'd15, 8'd15}, 1'b0, 0);
      run_op("w8_s_m7_2", 2, 1'b1, 32'h000000F9, 32'd2, 9, {112'd0, 8'hFF, 8'hFD}, 1'b0, 0);

      // Reset in the middle of an 8-bit operation
      sgn = 1'b0; op1 = 32'd200; op2 = 32'd3; st_8 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("w8_rst_busy", {127'd0, bsy_8}, 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("w8_rst_out", {res_8, rdy_8, bsy_8, dbz_8}, '0);
      rst = 1'b0; st_8 = 1'b0;
      @(posedge clk); #1;
      run_op("w8_after_rst", 2, 1'b0, 32'd200, 32'd3, 9, {112'd0, 8'd2, 8'd66}, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_unit_p.md
Name: div_unit_p

Overview:
Parametrised successor to the core's fixed 32-bit divider, serving the EX stage for DIV/DIVU. It performs a radix-2 restoring division of configurable width. It adds four behaviours the old divider lacks: early-out, a divide-by-zero flag, defined overflow behaviour, and annul at any busy state. EX drives the operands and start, holds start while stalled via stallreq, and consumes the {remainder, quotient} result into HI/LO.

Parameters:
WIDTH, 32, operand width in bits; legal range 4..64.
EARLY_OUT, 1, when 1, finish in one cycle if |dividend| < |divisor|.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
clk  in  1  core clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
signed_div_i  in  1  1 = signed (two's complement) division, 0 = unsigned.
opdata1_i  in  WIDTH  dividend.
opdata2_i  in  WIDTH  divisor.
start_i  in  1  request; must be held high until the result is consumed.
annul_i  in  1  abort the current operation.
result_o  out  2*WIDTH  {remainder, quotient}.
ready_o  out  1  result valid.
busy_o  out  1  operation in flight; high in ON only.
div_by_zero_o  out  1  divisor was zero; valid while ready_o=1.

Behaviour:
- Reset (rst=1 at edge): state IDLE, counter 0, all outputs 0.
- States: IDLE, ON, END. The state type is a shared enum.
- IDLE:
  - On start_i=1 and annul_i=0, latch signed_div_i and |opdata1_i|, |opdata2_i| (abs applied only when signed), plus both operand sign bits.
  - Divisor == 0 -> END in one edge; quotient 0, remainder 0, div_by_zero_o=1.
  - Otherwise, EARLY_OUT=1 and |dividend| < |divisor| -> END in one edge; quotient 0, remainder = opdata1_i unmodified.
  - Otherwise -> ON, counter=0.
- ON:
  - Each edge does one shift-subtract step on a (2*WIDTH+1)-bit working register.
  - The WIDTH-th step applies sign correction, writes result_o and moves to END.
  - Latency: ready_o is visible WIDTH+1 cycles after start is sampled in the full path, 1 cycle in the early-out and div-by-zero paths.
- Sign correction (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Most-negative / -1: quotient = most-negative (wraps), remainder 0, no flag.
- END:
  - ready_o=1 and result_o stable.
  - start_i=0 -> IDLE next edge. start_i stays 1 (pipeline stalled) -> remain in END.
- Annul: annul_i=1 in ON or END -> IDLE next edge, result discarded. Annul has priority over start and over completion on the same edge.
- Start or operand changes while in ON or END are ignored; operands are captured only in IDLE.
- result_o = 0 and div_by_zero_o = 0 whenever ready_o=0.
- rst asserted mid-operation: IDLE next edge, outputs 0, no residual state.
- No back-to-back acceptance: at least one IDLE cycle separates operations.

Decomposition:
- Shared package entries:
  - div state enum (DivIdle, DivOn, DivEnd).
  - DivStart/DivStop and DivResultReady/DivResultNotReady constants alongside the existing global defines.
- The DoubleReg_t alias stays for WIDTH=32 instances. Widths derive from parameters inside the module.
- Natural sub-module: div_step_p, a combinational single restoring step (WIDTH parameter; in: partial remainder and divisor; out: next partial remainder and quotient bit). Instantiated once in div_unit_p.

Test Plan:
All cases below use WIDTH=32 unless stated.
- Unsigned 100/7, start held -> ready_o rises on the 33rd cycle after start is sampled, result_o = {32'd2, 32'd14}, div_by_zero_o=0.
- Signed -100/7 (0xFFFFFF9C / 7) -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divisor 0, dividend 0x1234 -> ready_o after 1 cycle, result 0, div_by_zero_o=1. Deassert start -> IDLE next cycle, all outputs 0.
- EARLY_OUT=1, unsigned 5/9 -> ready after 1 cycle, {32'd5, 32'd0}. Same operands with EARLY_OUT=0 -> same result after 33 cycles.
- Annul on cycle 10 of ON (busy_o=1) -> IDLE next cycle, ready_o never asserts. A following start with 1000/10 -> {0, 100}. Hold start 5 extra cycles in END -> result stable throughout.
- WIDTH=8 instance, unsigned 255/16 -> {8'd15, 8'd15} after 9 cycles. rst asserted mid-ON -> all outputs 0 next cycle.
